// File: rtl/guess_game_ctrl_pkg.sv
// Shared types and constants for the keypad number-guessing controller.
package guess_game_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DATA_W  = 3 * DIGIT_W;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TRIES_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CHECK = 3'd2,
    ST_SHOW  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    HINT_NONE = 2'b00,
    HINT_LOW  = 2'b01,
    HINT_HIGH = 2'b10,
    HINT_EQ   = 2'b11
  } hint_e;

  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_BS    = 4'hB;
  localparam logic [DIGIT_W-1:0] KEY_CLR   = 4'hC;
  localparam logic [DIGIT_W-1:0] KEY_NEW   = 4'hD;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/guess_game_ctrl_bcd3_counter.sv
// Free-running 3-digit BCD counter 000..999 with wrap; supplies the secret seed.
module bcd3_counter
  import guess_game_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] count_o
);

  logic [DATA_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (count_q[3:0] == 4'd9) begin
      count_d[3:0] = 4'd0;
      if (count_q[7:4] == 4'd9) begin
        count_d[7:4] = 4'd0;
        if (count_q[11:8] == 4'd9) count_d[11:8] = 4'd0;
        else                       count_d[11:8] = 4'(count_q[11:8] + 4'd1);
      end else begin
        count_d[7:4] = 4'(count_q[7:4] + 4'd1);
      end
    end else begin
      count_d[3:0] = 4'(count_q[3:0] + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing-game sequencer: assembles a 3-digit BCD guess from key events,
// compares it with a latched pseudo-random secret and tracks tries/hints.
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TRIES   = 7,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  output logic [DATA_W-1:0]  data,
  output logic [TRIES_W-1:0] tries,
  output logic [1:0]         hint,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic [2:0]         game_state,
  output logic               win,
  output logic               lose
);

  localparam int unsigned TMR_W = $clog2(SHOW_CYCLES + 1);

  state_e             state_q, state_d;
  hint_e              hint_q, hint_d;
  logic [DATA_W-1:0]  entry_q, entry_d;
  logic [DATA_W-1:0]  secret_q, secret_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic [DATA_W-1:0]  seed;
  logic               key_new;

  bcd3_counter u_seed (
    .clk    (clk),
    .rst    (rst),
    .count_o(seed)
  );

  assign key_new   = key_valid && (key_code == KEY_NEW);
  assign tries_inc = (tries_q >= TRIES_W'(MAX_TRIES)) ? tries_q : TRIES_W'(tries_q + 4'd1);

  always_comb begin
    state_d  = state_q;
    hint_d   = hint_q;
    entry_d  = entry_q;
    secret_d = secret_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          secret_d = seed;
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (cnt_q != 2'd3) begin
              entry_d = {entry_q[DATA_W-DIGIT_W-1:0], key_code};
              cnt_d   = CNT_W'(cnt_q + 2'd1);
            end
          end else if (key_code == KEY_BS) begin
            if (cnt_q != 2'd0) begin
              entry_d = {4'h0, entry_q[DATA_W-1:DIGIT_W]};
              cnt_d   = CNT_W'(cnt_q - 2'd1);
            end
          end else if (key_code == KEY_CLR) begin
            entry_d = '0;
            cnt_d   = '0;
          end else if (key_code == KEY_ENTER) begin
            if (cnt_q == 2'd3) state_d = ST_CHECK;
          end
        end
      end
      // Single-cycle compare; every key arriving here is dropped.
      ST_CHECK: begin
        if (entry_q == secret_q) begin
          hint_d  = HINT_EQ;
          state_d = ST_WIN;
        end else begin
          hint_d  = (entry_q < secret_q) ? HINT_LOW : HINT_HIGH;
          tries_d = tries_inc;
          if (tries_inc == TRIES_W'(MAX_TRIES)) begin
            state_d = ST_LOSE;
          end else begin
            state_d = ST_SHOW;
            tmr_d   = '0;
          end
        end
      end
      ST_SHOW: begin
        if (tmr_q == TMR_W'(SHOW_CYCLES - 1)) begin
          entry_d = '0;
          cnt_d   = '0;
          hint_d  = HINT_NONE;
          state_d = ST_ENTRY;
        end else begin
          tmr_d = TMR_W'(tmr_q + 1'b1);
        end
      end
      ST_WIN, ST_LOSE: ;
      default: state_d = ST_IDLE;
    endcase

    if (key_new && (state_q != ST_IDLE) && (state_q != ST_CHECK)) begin
      state_d = ST_IDLE;
      entry_d = '0;
      cnt_d   = '0;
      tries_d = '0;
      hint_d  = HINT_NONE;
    end

    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
    data_d = (win_d || lose_d) ? secret_d : entry_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hint_q   <= HINT_NONE;
      entry_q  <= '0;
      secret_q <= '0;
      data_q   <= '0;
      tries_q  <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hint_q   <= hint_d;
      entry_q  <= entry_d;
      secret_q <= secret_d;
      data_q   <= data_d;
      tries_q  <= tries_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign data       = data_q;
  assign tries      = tries_q;
  assign hint       = hint_q;
  assign digit_cnt  = cnt_q;
  assign game_state = state_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule
